pwm_duty_meas: RTL and testbench

PWM_DUTY_MEAS -- requirements
Module: pwm_duty_meas

---
 rtl/pwm_duty_meas_pkg.sv | 26 ++
 rtl/pwm_in_sync.sv | 41 ++++
 rtl/pwm_duty_meas.sv | 215 +++++++++++++++++++++
 tb/tb_pwm_duty_meas.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_duty_meas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_duty_meas_pkg
// Description : Shared constants for the PWM duty-cycle measurement block:
//               FSM state encoding, duty-code width and default sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_duty_meas_pkg;

   // Width of the duty code (matches the PWM generator compare value)
   localparam int DUTY_W         = 10;

   // Default counter width and log2 of clocks per duty slot
   localparam int DEF_CNT_W      = 16;
   localparam int DEF_SLOT_SHIFT = 4;

   // Measurement FSM state encoding
   localparam int ST_W = 2;
   typedef logic [ST_W-1:0] state_t;

   localparam state_t C_ST_IDLE = 2'd0;
   localparam state_t C_ST_HIGH = 2'd1;
   localparam state_t C_ST_LOW  = 2'd2;

endpackage : pwm_duty_meas_pkg
`default_nettype wire

// File: rtl/pwm_in_sync.sv
`default_nettype none
// ============================================================================
// Module      : pwm_in_sync
// Description : Two-flop synchronizer for the asynchronous PWM input plus a
//               delay flop for single-cycle rise/fall edge detection.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_in_sync
   import pwm_duty_meas_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic pwm_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic r_s1;
   logic r_s2;
   logic r_s3;

   // Metastability chain (s1, s2) followed by the edge-detect delay stage (s3)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= pwm_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign level = r_s2;
   assign rise  = r_s2 & ~r_s3;
   assign fall  = ~r_s2 & r_s3;

endmodule : pwm_in_sync
`default_nettype wire

// File: rtl/pwm_duty_meas.sv
`default_nettype none
// ============================================================================
// Module      : pwm_duty_meas
// Description : Measures high time, period and duty code (in PWM slots) of an
//               asynchronous PWM waveform, one result per rising-edge frame.
//               Flags a stuck input when no edge is seen for a full counter
//               range.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_meas
   import pwm_duty_meas_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int SLOT_SHIFT = DEF_SLOT_SHIFT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pwm_in,
   output logic              meas_valid,
   output logic [CNT_W-1:0]  high_cycles,
   output logic [CNT_W-1:0]  period_cycles,
   output logic [DUTY_W-1:0] duty_code,
   output logic              stuck,
   output logic              stuck_level
);

   // Zero-extended view of the high count wide enough to slice the duty
   // field and test the bits above it for any counter/shift combination.
   localparam int              EXT_W     = CNT_W + SLOT_SHIFT + DUTY_W + 1;
   localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
   localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

   // Synchronized input and edge strobes
   logic w_level;
   logic w_rise;
   logic w_fall;

   // FSM
   state_t r_state;
   state_t w_state_next;

   // Datapath
   logic [CNT_W-1:0]  r_pcnt;
   logic [CNT_W-1:0]  r_hlatch;
   logic [CNT_W-1:0]  w_pcnt_inc;
   logic              w_at_max;
   logic              w_no_edge;

   // FSM control decodes
   logic w_load_one;
   logic w_inc;
   logic w_latch_high;
   logic w_publish;
   logic w_timeout;

   // Duty code derivation
   logic [EXT_W-1:0]  w_hl_ext;
   logic              w_duty_over;
   logic [DUTY_W-1:0] w_duty_slots;
   logic [DUTY_W-1:0] w_duty_next;

   // Registered outputs
   logic              r_meas_valid;
   logic [CNT_W-1:0]  r_high_cycles;
   logic [CNT_W-1:0]  r_period_cycles;
   logic [DUTY_W-1:0] r_duty_code;
   logic              r_stuck;
   logic              r_stuck_level;

   pwm_in_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .pwm_in (pwm_in),
      .level  (w_level),
      .rise   (w_rise),
      .fall   (w_fall)
   );

   assign w_at_max  = (r_pcnt == C_CNT_MAX);
   assign w_no_edge = ~w_rise & ~w_fall;

   // Saturating increment: an edge landing on an all-ones count is still a
   // normal edge, and the counter must not wrap while doing so.
   assign w_pcnt_inc = w_at_max ? C_CNT_MAX : (r_pcnt + C_CNT_ONE);

   // Duty code is the slot index of the latched high time, saturated when
   // the high time exceeds the largest representable slot.
   assign w_hl_ext     = EXT_W'(r_hlatch);
   assign w_duty_over  = |(w_hl_ext >> (SLOT_SHIFT + DUTY_W));
   assign w_duty_slots = w_hl_ext[SLOT_SHIFT +: DUTY_W];
   assign w_duty_next  = w_duty_over ? {DUTY_W{1'b1}} : w_duty_slots;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= C_ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next-state: timeout wins over increment, edges win over timeout
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         C_ST_IDLE: begin
            if (w_rise) begin
               w_state_next = C_ST_HIGH;
            end
         end
         C_ST_HIGH: begin
            if (w_timeout) begin
               w_state_next = C_ST_IDLE;
            end else if (w_fall) begin
               w_state_next = C_ST_LOW;
            end
         end
         C_ST_LOW: begin
            if (w_timeout) begin
               w_state_next = C_ST_IDLE;
            end else if (w_rise) begin
               w_state_next = C_ST_HIGH;
            end
         end
         default: begin
            w_state_next = C_ST_IDLE;
         end
      endcase
   end

   // FSM output decode: per-state datapath controls
   always_comb begin
      w_load_one   = 1'b0;
      w_inc        = 1'b0;
      w_latch_high = 1'b0;
      w_publish    = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         C_ST_IDLE: begin
            w_load_one = w_rise;
         end
         C_ST_HIGH: begin
            if (w_at_max && w_no_edge) begin
               w_timeout = 1'b1;
            end else begin
               w_inc        = 1'b1;
               w_latch_high = w_fall;
            end
         end
         C_ST_LOW: begin
            if (w_at_max && w_no_edge) begin
               w_timeout = 1'b1;
            end else if (w_rise) begin
               w_publish  = 1'b1;
               w_load_one = 1'b1;
            end else begin
               w_inc = 1'b1;
            end
         end
         default: begin
            w_load_one = 1'b0;
         end
      endcase
   end

   // Period counter and high-time latch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pcnt   <= '0;
         r_hlatch <= '0;
      end else begin
         if (w_load_one) begin
            r_pcnt <= C_CNT_ONE;
         end else if (w_inc) begin
            r_pcnt <= w_pcnt_inc;
         end
         if (w_latch_high) begin
            r_hlatch <= r_pcnt;
         end
      end
   end

   // Measurement results and stuck status; results hold across a timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meas_valid    <= 1'b0;
         r_high_cycles   <= '0;
         r_period_cycles <= '0;
         r_duty_code     <= '0;
         r_stuck         <= 1'b0;
         r_stuck_level   <= 1'b0;
      end else begin
         r_meas_valid <= w_publish;
         if (w_publish) begin
            r_high_cycles   <= r_hlatch;
            r_period_cycles <= r_pcnt;
            r_duty_code     <= w_duty_next;
            r_stuck         <= 1'b0;
         end else if (w_timeout) begin
            r_stuck       <= 1'b1;
            r_stuck_level <= w_level;
            r_duty_code   <= {DUTY_W{w_level}};
         end
      end
   end

   assign meas_valid    = r_meas_valid;
   assign high_cycles   = r_high_cycles;
   assign period_cycles = r_period_cycles;
   assign duty_code     = r_duty_code;
   assign stuck         = r_stuck;
   assign stuck_level   = r_stuck_level;

endmodule : pwm_duty_meas
`default_nettype wire

// File: tb/tb_pwm_duty_meas.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_duty_meas
// Description : Self-checking bench for pwm_duty_meas. Instance A uses the
//               default sizing; instance B uses a short counter so that
//               timeout and saturation corners are reachable quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_meas;

   localparam int AW = 16;
   localparam int AS = 4;
   localparam int BW = 12;
   localparam int BS = 1;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] per;
      logic [31:0] duty;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          pwm_a;
   logic          pwm_b;

   logic          mv_a, stuck_a, sl_a;
   logic [AW-1:0] hi_a, per_a;
   logic [9:0]    duty_a;

   logic          mv_b, stuck_b, sl_b;
   logic [BW-1:0] hi_b, per_b;
   logic [9:0]    duty_b;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea;
   exp_t eb;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pwm_duty_meas #(.CNT_W(AW), .SLOT_SHIFT(AS)) dut_a (
      .clk           (clk),
      .rst           (rst),
      .pwm_in        (pwm_a),
      .meas_valid    (mv_a),
      .high_cycles   (hi_a),
      .period_cycles (per_a),
      .duty_code     (duty_a),
      .stuck         (stuck_a),
      .stuck_level   (sl_a)
   );

   pwm_duty_meas #(.CNT_W(BW), .SLOT_SHIFT(BS)) dut_b (
      .clk           (clk),
      .rst           (rst),
      .pwm_in        (pwm_b),
      .meas_valid    (mv_b),
      .high_cycles   (hi_b),
      .period_cycles (per_b),
      .duty_code     (duty_b),
      .stuck         (stuck_b),
      .stuck_level   (sl_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference duty: slot index of the high time, clipped to 1023
   function automatic logic [31:0] duty_ref(input int h, input int shift);
      int s;
      s = h >> shift;
      return (s > 1023) ? 32'd1023 : 32'(s);
   endfunction

   task automatic pa(input logic lvl, input int n);
      pwm_a = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic pb(input logic lvl, input int n);
      pwm_b = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic fa(input int h, input int l);
      pa(1'b1, h);
      pa(1'b0, l);
      qa.push_back('{32'(h), 32'(h + l), duty_ref(h, AS)});
   endtask

   task automatic fb(input int h, input int l);
      pb(1'b1, h);
      pb(1'b0, l);
      qb.push_back('{32'(h), 32'(h + l), duty_ref(h, BS)});
   endtask

   // Scoreboard: every strobe must match the oldest outstanding frame
   always @(negedge clk) begin
      if (mv_a === 1'b1) begin
         checks++;
         assert (qa.size() != 0) else begin
            failures++;
            $error("FAIL a_unexpected_valid observed=strobe expected=none");
         end
         if (qa.size() != 0) begin
            ea = qa.pop_front();
            chk("a_high_cycles", 32'(hi_a), ea.hi);
            chk("a_period_cycles", 32'(per_a), ea.per);
            chk("a_duty_code", 32'(duty_a), ea.duty);
            chk("a_stuck_on_valid", 32'(stuck_a), 32'd0);
         end
      end
      if (mv_b === 1'b1) begin
         checks++;
         assert (qb.size() != 0) else begin
            failures++;
            $error("FAIL b_unexpected_valid observed=strobe expected=none");
         end
         if (qb.size() != 0) begin
            eb = qb.pop_front();
            chk("b_high_cycles", 32'(hi_b), eb.hi);
            chk("b_period_cycles", 32'(per_b), eb.per);
            chk("b_duty_code", 32'(duty_b), eb.duty);
            chk("b_stuck_on_valid", 32'(stuck_b), 32'd0);
         end
      end
   end

   initial begin
      rst   = 1'b1;
      pwm_a = 1'b0;
      pwm_b = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("a_rst_valid", 32'(mv_a), 32'd0);
      chk("a_rst_high", 32'(hi_a), 32'd0);
      chk("a_rst_period", 32'(per_a), 32'd0);
      chk("a_rst_duty", 32'(duty_a), 32'd0);
      chk("a_rst_stuck", 32'(stuck_a), 32'd0);
      chk("a_rst_stuck_level", 32'(sl_a), 32'd0);
      chk("b_rst_duty", 32'(duty_b), 32'd0);
      chk("b_rst_stuck", 32'(stuck_b), 32'd0);
      rst = 1'b0;

      // Full-scale frames: 16256 high of 16384
      pa(1'b0, 20);
      fa(16256, 128);
      fa(16256, 128);

      // Closing rise changes mid-cycle; strobe is seen after the third edge
      pwm_a = 1'b1;
      @(negedge clk);
      chk("a_latency_1", 32'(mv_a), 32'd0);
      @(negedge clk);
      chk("a_latency_2", 32'(mv_a), 32'd0);
      @(negedge clk);
      chk("a_latency_3", 32'(mv_a), 32'd1);
      pa(1'b1, 2);
      pa(1'b0, 3);
      qa.push_back('{32'd5, 32'd8, 32'd0});

      // Fastest legal square wave, then a short irregular frame
      for (int i = 0; i < 8; i++) begin
         fa(1, 1);
      end
      fa(3, 5);
      pa(1'b1, 6);
      chk("a_drain_1", 32'(qa.size()), 32'd0);

      // Asynchronous reset in the middle of a high phase
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("a_midrst_high", 32'(hi_a), 32'd0);
      chk("a_midrst_period", 32'(per_a), 32'd0);
      chk("a_midrst_valid", 32'(mv_a), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      pa(1'b0, 10);
      fa(7, 9);
      pa(1'b1, 4);
      chk("a_drain_2", 32'(qa.size()), 32'd0);

      // B has been held low since reset for far longer than its timeout
      chk("b_idle_stuck", 32'(stuck_b), 32'd0);
      chk("b_idle_high", 32'(hi_b), 32'd0);

      // Slot scaling, exact top slot, saturation, period at all-ones
      pb(1'b0, 10);
      fb(1000, 200);
      fb(2047, 100);
      fb(2500, 500);
      fb(2000, 2095);

      // One clock longer period: times out in LOW just before the rise
      pb(1'b1, 2000);
      pb(1'b0, 2096);
      pb(1'b1, 10);
      chk("b_drain_1", 32'(qb.size()), 32'd0);
      chk("b_lowto_stuck", 32'(stuck_b), 32'd1);
      chk("b_lowto_level", 32'(sl_b), 32'd0);
      chk("b_lowto_duty", 32'(duty_b), 32'd0);
      chk("b_lowto_high_held", 32'(hi_b), 32'd2000);
      chk("b_lowto_period_held", 32'(per_b), 32'd4095);

      // Frame after the arming rise, then held high into a timeout
      pb(1'b0, 20);
      qb.push_back('{32'd10, 32'd30, 32'd5});
      pb(1'b1, 10);
      chk("b_stuck_cleared", 32'(stuck_b), 32'd0);
      pb(1'b1, 4990);
      chk("b_highto_stuck", 32'(stuck_b), 32'd1);
      chk("b_highto_level", 32'(sl_b), 32'd1);
      chk("b_highto_duty", 32'(duty_b), 32'd1023);
      chk("b_highto_high_held", 32'(hi_b), 32'd10);
      chk("b_highto_period_held", 32'(per_b), 32'd30);

      // Recovery: single-clock pulse frame arms, next rise publishes
      pb(1'b0, 10);
      fb(1, 3);
      chk("b_stuck_after_arm", 32'(stuck_b), 32'd1);
      fb(5, 6);
      pb(1'b1, 10);
      chk("b_stuck_recovered", 32'(stuck_b), 32'd0);
      chk("b_drain_2", 32'(qb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_pwm_duty_meas
`default_nettype wire
